// File: rtl/conv2_pkg.sv
// Shared constants and types for the conv2 window generator.
package conv2_pkg;

  localparam int IMG_W     = 12;
  localparam int K         = 5;
  localparam int DATA_BITS = 12;
  localparam int TAPS      = K * K;
  localparam int SR_DEPTH  = IMG_W * (K - 1) + K;

  typedef logic signed [DATA_BITS-1:0] pix_t;

  // Shift-register index feeding window tap (r, c); row 0 / column 0 is the oldest pixel.
  function automatic int tap_src(input int img_w, input int k, input int r, input int c);
    return (k - 1 - r) * img_w + (k - 1 - c);
  endfunction

endpackage

// File: rtl/conv2_line_shift.sv
// Single-channel raster line buffer: an IMG_W*(K-1)+K deep shift register whose
// K*K window taps are plain slices of the stored pixels.
module conv2_line_shift #(
  parameter int IMG_W     = conv2_pkg::IMG_W,
  parameter int K         = conv2_pkg::K,
  parameter int DATA_BITS = conv2_pkg::DATA_BITS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic [DATA_BITS-1:0]            din,
  output logic [K*K-1:0][DATA_BITS-1:0]   taps
);
  import conv2_pkg::*;

  localparam int DEPTH = IMG_W * (K - 1) + K;

  logic [DEPTH-1:0][DATA_BITS-1:0] sr_q, sr_d;

  // Next state: clear on reset, shift the newest pixel into entry 0 on enable, else hold.
  // NOTE: every path starts from a default (hold), so no latch is inferred in this always_comb.
  always_comb begin
    sr_d = sr_q;
    if (!rst_n) begin
      // NOTE: this storage is deliberately reset; downstream sees the taps and they must read 0 after reset.
      sr_d = '0;
    end else if (en) begin
      sr_d = {sr_q[DEPTH-2:0], din};
    end
  end

  // State register.
  // NOTE: non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      localparam int SRC = tap_src(IMG_W, K, r, c);
      assign taps[r*K+c] = sr_q[SRC];
    end
  end

endmodule

// File: rtl/conv2_window_buf.sv
// conv2 window generator: three line buffers plus raster position counters that
// strobe valid_out_buf whenever the accepted pixel completes a full KxK window.
module conv2_window_buf #(
  parameter int IMG_W     = conv2_pkg::IMG_W,
  parameter int K         = conv2_pkg::K,
  parameter int DATA_BITS = conv2_pkg::DATA_BITS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        valid_in,
  input  logic signed [DATA_BITS-1:0] data_in_1,
  input  logic signed [DATA_BITS-1:0] data_in_2,
  input  logic signed [DATA_BITS-1:0] data_in_3,
  output logic signed [DATA_BITS-1:0] data_out1_0,  data_out1_1,  data_out1_2,  data_out1_3,  data_out1_4,
  output logic signed [DATA_BITS-1:0] data_out1_5,  data_out1_6,  data_out1_7,  data_out1_8,  data_out1_9,
  output logic signed [DATA_BITS-1:0] data_out1_10, data_out1_11, data_out1_12, data_out1_13, data_out1_14,
  output logic signed [DATA_BITS-1:0] data_out1_15, data_out1_16, data_out1_17, data_out1_18, data_out1_19,
  output logic signed [DATA_BITS-1:0] data_out1_20, data_out1_21, data_out1_22, data_out1_23, data_out1_24,
  output logic signed [DATA_BITS-1:0] data_out2_0,  data_out2_1,  data_out2_2,  data_out2_3,  data_out2_4,
  output logic signed [DATA_BITS-1:0] data_out2_5,  data_out2_6,  data_out2_7,  data_out2_8,  data_out2_9,
  output logic signed [DATA_BITS-1:0] data_out2_10, data_out2_11, data_out2_12, data_out2_13, data_out2_14,
  output logic signed [DATA_BITS-1:0] data_out2_15, data_out2_16, data_out2_17, data_out2_18, data_out2_19,
  output logic signed [DATA_BITS-1:0] data_out2_20, data_out2_21, data_out2_22, data_out2_23, data_out2_24,
  output logic signed [DATA_BITS-1:0] data_out3_0,  data_out3_1,  data_out3_2,  data_out3_3,  data_out3_4,
  output logic signed [DATA_BITS-1:0] data_out3_5,  data_out3_6,  data_out3_7,  data_out3_8,  data_out3_9,
  output logic signed [DATA_BITS-1:0] data_out3_10, data_out3_11, data_out3_12, data_out3_13, data_out3_14,
  output logic signed [DATA_BITS-1:0] data_out3_15, data_out3_16, data_out3_17, data_out3_18, data_out3_19,
  output logic signed [DATA_BITS-1:0] data_out3_20, data_out3_21, data_out3_22, data_out3_23, data_out3_24,
  output logic                        valid_out_buf
);

  localparam int TAPS = K * K;
  localparam int CW   = $clog2(IMG_W);
  localparam logic [CW-1:0] LAST_POS  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] WIN_START = CW'(K - 1);

  logic [TAPS-1:0][DATA_BITS-1:0] taps1, taps2, taps3;
  logic [CW-1:0] col_q, col_d, row_q, row_d;
  logic          valid_q, valid_d;

  conv2_line_shift #(.IMG_W(IMG_W), .K(K), .DATA_BITS(DATA_BITS)) u_ch1 (
    .clk(clk), .rst_n(rst_n), .en(valid_in), .din(data_in_1), .taps(taps1));
  conv2_line_shift #(.IMG_W(IMG_W), .K(K), .DATA_BITS(DATA_BITS)) u_ch2 (
    .clk(clk), .rst_n(rst_n), .en(valid_in), .din(data_in_2), .taps(taps2));
  conv2_line_shift #(.IMG_W(IMG_W), .K(K), .DATA_BITS(DATA_BITS)) u_ch3 (
    .clk(clk), .rst_n(rst_n), .en(valid_in), .din(data_in_3), .taps(taps3));

  // Raster position of the next pixel and the window-complete decision for the current one.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    if (!rst_n) begin
      col_d = '0;
      row_d = '0;
    end else if (valid_in) begin
      // Row gating also hides windows that would straddle the previous image.
      valid_d = (row_q >= WIN_START) && (col_q >= WIN_START);
      if (col_q == LAST_POS) begin
        col_d = '0;
        row_d = (row_q == LAST_POS) ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Counter and strobe registers.
  always_ff @(posedge clk) begin
    col_q   <= col_d;
    row_q   <= row_d;
    valid_q <= valid_d;
  end

  assign valid_out_buf = valid_q;

  assign data_out1_0  = taps1[0];  assign data_out1_1  = taps1[1];  assign data_out1_2  = taps1[2];  assign data_out1_3  = taps1[3];  assign data_out1_4  = taps1[4];
  assign data_out1_5  = taps1[5];  assign data_out1_6  = taps1[6];  assign data_out1_7  = taps1[7];  assign data_out1_8  = taps1[8];  assign data_out1_9  = taps1[9];
  assign data_out1_10 = taps1[10]; assign data_out1_11 = taps1[11]; assign data_out1_12 = taps1[12]; assign data_out1_13 = taps1[13]; assign data_out1_14 = taps1[14];
  assign data_out1_15 = taps1[15]; assign data_out1_16 = taps1[16]; assign data_out1_17 = taps1[17]; assign data_out1_18 = taps1[18]; assign data_out1_19 = taps1[19];
  assign data_out1_20 = taps1[20]; assign data_out1_21 = taps1[21]; assign data_out1_22 = taps1[22]; assign data_out1_23 = taps1[23]; assign data_out1_24 = taps1[24];
  assign data_out2_0  = taps2[0];  assign data_out2_1  = taps2[1];  assign data_out2_2  = taps2[2];  assign data_out2_3  = taps2[3];  assign data_out2_4  = taps2[4];
  assign data_out2_5  = taps2[5];  assign data_out2_6  = taps2[6];  assign data_out2_7  = taps2[7];  assign data_out2_8  = taps2[8];  assign data_out2_9  = taps2[9];
  assign data_out2_10 = taps2[10]; assign data_out2_11 = taps2[11]; assign data_out2_12 = taps2[12]; assign data_out2_13 = taps2[13]; assign data_out2_14 = taps2[14];
  assign data_out2_15 = taps2[15]; assign data_out2_16 = taps2[16]; assign data_out2_17 = taps2[17]; assign data_out2_18 = taps2[18]; assign data_out2_19 = taps2[19];
  assign data_out2_20 = taps2[20]; assign data_out2_21 = taps2[21]; assign data_out2_22 = taps2[22]; assign data_out2_23 = taps2[23]; assign data_out2_24 = taps2[24];
  assign data_out3_0  = taps3[0];  assign data_out3_1  = taps3[1];  assign data_out3_2  = taps3[2];  assign data_out3_3  = taps3[3];  assign data_out3_4  = taps3[4];
  assign data_out3_5  = taps3[5];  assign data_out3_6  = taps3[6];  assign data_out3_7  = taps3[7];  assign data_out3_8  = taps3[8];  assign data_out3_9  = taps3[9];
  assign data_out3_10 = taps3[10]; assign data_out3_11 = taps3[11]; assign data_out3_12 = taps3[12]; assign data_out3_13 = taps3[13]; assign data_out3_14 = taps3[14];
  assign data_out3_15 = taps3[15]; assign data_out3_16 = taps3[16]; assign data_out3_17 = taps3[17]; assign data_out3_18 = taps3[18]; assign data_out3_19 = taps3[19];
  assign data_out3_20 = taps3[20]; assign data_out3_21 = taps3[21]; assign data_out3_22 = taps3[22]; assign data_out3_23 = taps3[23]; assign data_out3_24 = taps3[24];

endmodule
